// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: stage payload
// widths, payload field offsets, the bubble constant and the occupancy encoding.
package pipe_stage_reg_pkg;

    localparam int PIPE_DW_FD = 64;   // {instr, pc}
    localparam int PIPE_DW_DE = 128;  // {imm, rs2_val, rs1_val, pc}
    localparam int PIPE_DW_EM = 72;   // {ctrl, store_val, alu_res}
    localparam int PIPE_DW_MW = 40;   // {ctrl, wb_val}

    localparam int FD_PC_LSB     = 0;
    localparam int FD_INSTR_LSB  = 32;
    localparam int DE_PC_LSB     = 0;
    localparam int DE_RS1_LSB    = 32;
    localparam int DE_RS2_LSB    = 64;
    localparam int DE_IMM_LSB    = 96;
    localparam int EM_ALU_LSB    = 0;
    localparam int EM_STORE_LSB  = 32;
    localparam int EM_CTRL_LSB   = 64;
    localparam int MW_WB_LSB     = 0;
    localparam int MW_CTRL_LSB   = 32;

    localparam logic [PIPE_DW_DE-1:0] BUBBLE_WORD = '0;

    // Encoded as {main_v, skid_v}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake with a two-entry skid
// buffer so in_ready is purely registered, plus flush and a saturating stall counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | nothing held, accepting
//   ST_ONE   | main holds the head word, accepting
//   ST_FULL  | main and skid both hold words, in_ready low
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter bit ZERO_ON_EMPTY = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              accept;
    logic              deliver;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    assign {main_v, skid_v} = state;
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = (ZERO_ON_EMPTY && !main_v) ? '0 : main_d;
    assign accept    = in_valid && in_ready;
    assign deliver   = main_v && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (deliver && accept) begin
                    load_main = 1'b1;
                end else if (deliver) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Data registers only load on a real transfer to keep held data stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_d <= '0;
            skid_d <= '0;
        end else begin
            if (load_main) begin
                main_d <= main_from_skid ? skid_d : in_data;
            end
            if (load_skid) begin
                skid_d <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed-field, stall-by-write-enable stage registers between pipeline stages.
- Carries one opaque DATA_W-bit payload word (PC, instr, ALU result, etc. concatenated by the instantiating stage).
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure is registered and throughput stays one word per cycle.
- Adds synchronous flush, a zero-on-bubble option and a saturating stall counter.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- ZERO_ON_EMPTY, 1, if 1 then out_data is forced to 0 whenever out_valid=0, so the bubble behaves as a NOP.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all held words.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word; depends on registered state only.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage and flags:
  - Storage is a main register (main_v, main_d) and a skid register (skid_v, skid_d).
  - out_valid = main_v.
  - out_data = main_d; forced to 0 when main_v=0 and ZERO_ON_EMPTY=1.
  - in_ready = !skid_v.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
- Reset (reset=0, asynchronous):
  - main_v, skid_v, main_d, skid_d and stall_cnt all go to 0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
  - Reset asserted mid-transfer loses any held words; no partial state survives.
- State machine, derived from {main_v, skid_v}:
  - EMPTY {0,0}:
    - Accept: main loads, go to ONE.
    - Otherwise: stay in EMPTY.
  - ONE {1,0}:
    - Deliver with accept: main reloads with in_data, stay in ONE.
    - Deliver without accept: go to EMPTY.
    - Accept without deliver: skid loads, go to FULL.
    - Neither: hold.
  - FULL {1,1}: in_ready=0, so no accept is possible.
    - Deliver: main <= skid, skid_v <= 0, go to ONE.
    - Otherwise: hold.
  - {0,1} is illegal and unreachable.
- Timing:
  - Latency is 1 cycle: a word accepted at edge N is visible on out_* after edge N.
  - Sustained throughput is 1 word/cycle when out_ready is held at 1.
  - Word order is strict FIFO; no duplication and no loss except through flush or reset.
- Flush:
  - Highest synchronous priority.
  - At the edge with flush=1: main_v and skid_v go to 0; main_d and skid_d go to 0.
  - An input handshake in the flush cycle is discarded.
  - A delivery in the flush cycle still counts as delivered downstream; the downstream side decides whether to honour it.
  - stall_cnt is unaffected by flush.
- Stall counter:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - cnt_clr=1 sets it to 0 at the edge and wins over a simultaneous increment.
- Data registers:
  - They do not load when not accepting, which limits toggling.
  - Held data stays stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package (def.v additions):
  - `PIPE_DW_FD, `PIPE_DW_DE, `PIPE_DW_EM, `PIPE_DW_MW: per-stage payload widths.
  - `BUBBLE_WORD: the zero constant used for flush and bubbles.
  - Payload field-offset macros for each stage.
- No sub-module is needed. The stall counter is small enough to stay inline. The two-register skid structure is the whole block.

Test Plan:
- Reset and single pass:
  - Hold reset=0 for 3 cycles → out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
  - Release, present in_data=32'h0040_3000 with valid for 1 cycle → out_valid=1 and out_data=32'h0040_3000 one cycle later.
- Streaming: out_ready=1, words 1..8 on consecutive cycles → the same 8 words appear on 8 consecutive cycles, in order, 1 cycle delayed.
- Back-pressure and skid:
  - out_ready=0, send A then B → in_ready drops to 0 after B; out_data holds A; stall_cnt increments each cycle.
  - Raise out_ready → A, then B, then in_ready=1.
- Flush in FULL state: with A and B held, flush=1 while in_valid=1 carries C → next cycle out_valid=0, out_data=0, in_ready=1; C is never delivered.
- Counter saturation and clear:
  - CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15.
  - cnt_clr together with a stall → stall_cnt=0.
- Async reset mid-stream: drop reset between clock edges while in FULL state → outputs go to reset values immediately, without waiting for a clock edge.
